// File: rtl/trng_postproc.sv
// Entropy post-processor: synchronises and XOR-combines raw channels, runs a
// repetition-count health test, debiases, and packs bits LSB-first into words.
module trng_postproc #(
  parameter int NUM_CH     = 6,
  parameter int WORD_W     = 8,
  parameter int RCT_CUTOFF = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic              i_sample,
  input  logic [NUM_CH-1:0] i_raw,
  input  logic              i_clr_fail,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_health_fail,
  output logic              o_overrun
);

  localparam int              CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);
  localparam logic [7:0]      CUTOFF   = 8'(RCT_CUTOFF);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NUM_CH-1:0] sync_p0, sync_p1;
  logic              b_p1;
  logic [1:0]        mode_q;
  logic              have_first, first;
  logic              have_n, first_n;
  logic [7:0]        rct_cnt, rct_next;
  logic              last_b;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] pack;
  logic              sample_ev, mode_chg, bypass, trip;
  logic              emit, emit_bit, full, xfer, accept, drop;

  // Stage p0/p1: two-flop synchronisers per raw channel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign b_p1      = ^sync_p1;
  assign sample_ev = i_sample & i_en;
  assign mode_chg  = (i_mode != mode_q);
  assign bypass    = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign rct_next  = ((rct_cnt == 8'd0) || (b_p1 != last_b)) ? 8'd1 : sat_inc(rct_cnt);
  assign trip      = sample_ev && (rct_next == CUTOFF) && (rct_cnt != CUTOFF);

  // Stage p1 -> packer: debias decision and pair-state update
  always_comb begin
    emit     = 1'b0;
    emit_bit = b_p1;
    have_n   = have_first;
    first_n  = first;
    if (!i_en || i_clr_fail || trip || mode_chg || o_health_fail) begin
      have_n  = 1'b0;
      first_n = 1'b0;
    end else if (sample_ev) begin
      if (bypass) begin
        emit = 1'b1;
      end else if (!have_first) begin
        have_n  = 1'b1;
        first_n = b_p1;
      end else begin
        have_n  = 1'b0;
        first_n = 1'b0;
        if (mode_q == 2'b01) begin
          emit     = (first != b_p1);
          emit_bit = first;
        end else begin
          emit     = 1'b1;
          emit_bit = first ^ b_p1;
        end
      end
    end
  end

  assign full   = (bit_cnt == FULL_CNT);
  assign xfer   = full && (!o_valid || i_ready);
  assign accept = emit && (!full || xfer);
  assign drop   = emit && full && !xfer;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q        <= 2'b00;
      have_first    <= 1'b0;
      first         <= 1'b0;
      rct_cnt       <= 8'd0;
      last_b        <= 1'b0;
      bit_cnt       <= '0;
      o_health_fail <= 1'b0;
      o_overrun     <= 1'b0;
      o_valid       <= 1'b0;
      o_data        <= '0;
    end else begin
      mode_q     <= i_mode;
      have_first <= have_n;
      first      <= first_n;

      if (i_clr_fail) begin
        rct_cnt <= 8'd0;
      end else if (sample_ev) begin
        rct_cnt <= rct_next;
        last_b  <= b_p1;
      end

      if (i_clr_fail)  o_health_fail <= 1'b0;
      else if (trip)   o_health_fail <= 1'b1;

      if (i_clr_fail)  o_overrun <= 1'b0;
      else if (drop)   o_overrun <= 1'b1;

      if (i_clr_fail || trip || mode_chg) bit_cnt <= '0;
      else if (xfer)                      bit_cnt <= accept ? CNT_W'(1) : '0;
      else if (accept)                    bit_cnt <= bit_cnt + CNT_W'(1);

      // Packer -> output register; a full word still leaves on a clearing edge
      if (xfer) begin
        o_valid <= 1'b1;
        o_data  <= pack;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < WORD_W; i++) begin
      if (accept && ((xfer && i == 0) || (!xfer && bit_cnt == CNT_W'(i))))
        pack[i] <= emit_bit;
    end
  end

endmodule

// File: tb/tb_trng_postproc.sv
// Directed bench for trng_postproc: bypass, von Neumann, health test,
// backpressure/overrun and mode switching with hand-computed words.
module tb_trng_postproc;

  localparam int NUM_CH = 3;
  localparam int WORD_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_en = 1'b1;
  logic [1:0]        i_mode = 2'b00;
  logic              i_sample = 1'b0;
  logic [NUM_CH-1:0] i_raw = '0;
  logic              i_clr_fail = 1'b0;
  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic              o_health_fail;
  logic              o_overrun;

  int checks = 0;
  int failures = 0;
  logic [WORD_W-1:0] got_q[$];

  trng_postproc #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .RCT_CUTOFF(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_mode(i_mode),
    .i_sample(i_sample), .i_raw(i_raw), .i_clr_fail(i_clr_fail),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_health_fail(o_health_fail), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_valid && i_ready) got_q.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] raw_for(input logic bv);
    logic [NUM_CH-1:0] r;
    r = NUM_CH'($urandom);
    r[0] = bv ^ (^r[NUM_CH-1:1]);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Samples bits[0..n-1] on consecutive edges, offset by the 2-edge sync latency
  task automatic stream(input logic [31:0] bits, input int n);
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) i_raw = raw_for(bits[k]);
      i_sample = (k >= 2);
      @(posedge i_clk);
      #1;
    end
    i_sample = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_sample = 1'b0;
    i_clr_fail = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
    got_q.delete();
  endtask

  initial begin
    do_reset();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_fail", o_health_fail, 0);
    check("rst_overrun", o_overrun, 0);

    // Bypass word 1,0,1,1,0,0,1,0 -> 8'h4D
    stream(32'h4D, 8);
    check("byp_not_yet", o_valid, 0);
    tick(1);
    check("byp_valid", o_valid, 1);
    check("byp_data", o_data, 8'h4D);
    tick(1);
    check("byp_valid_fall", o_valid, 0);

    // Von Neumann (0,1),(1,1),(1,0),(0,0) x4 -> 8'hAA
    do_reset();
    i_mode = 2'b01;
    tick(1);
    stream(32'h1E1E1E1E, 32);
    tick(3);
    check("vn_count", got_q.size(), 1);
    if (got_q.size() > 0) check("vn_word", got_q[0], 8'hAA);

    // Repetition-count trip on the 32nd identical sample
    do_reset();
    i_mode = 2'b00;
    tick(1);
    stream(32'h7FFFFFFF, 31);
    tick(2);
    check("rct_pre_fail", o_health_fail, 0);
    check("rct_words", got_q.size(), 3);
    if (got_q.size() > 2) check("rct_word3", got_q[2], 8'hFF);
    got_q.delete();
    stream(32'h1, 1);
    check("rct_fail", o_health_fail, 1);
    stream(32'h5555, 16);
    tick(3);
    check("rct_blocked", got_q.size(), 0);
    check("rct_sticky", o_health_fail, 1);
    i_clr_fail = 1'b1;
    tick(1);
    i_clr_fail = 1'b0;
    check("rct_cleared", o_health_fail, 0);
    stream(32'h55, 8);
    tick(3);
    check("rct_resume_cnt", got_q.size(), 1);
    if (got_q.size() > 0) check("rct_resume_word", got_q[0], 8'h55);

    // Backpressure: two words queued, 17th bit overruns
    do_reset();
    i_ready = 1'b0;
    stream(32'hA53C, 16);
    check("bp_valid", o_valid, 1);
    check("bp_data", o_data, 8'h3C);
    check("bp_no_ovr", o_overrun, 0);
    tick(4);
    check("bp_stable", o_data, 8'h3C);
    stream(32'h1, 1);
    check("bp_ovr", o_overrun, 1);
    check("bp_still_w1", o_data, 8'h3C);
    i_ready = 1'b1;
    tick(1);
    check("bp_swap_valid", o_valid, 1);
    check("bp_swap_data", o_data, 8'hA5);
    tick(1);
    check("bp_drain", o_valid, 0);
    i_clr_fail = 1'b1;
    tick(1);
    i_clr_fail = 1'b0;
    check("bp_ovr_clr", o_overrun, 0);

    // Mode switch 01 -> 10 discards 3 packed bits and a half pair
    do_reset();
    i_mode = 2'b01;
    tick(1);
    stream(32'h66, 7);
    i_mode = 2'b10;
    tick(1);
    stream(32'h5557, 16);
    tick(3);
    check("ms_count", got_q.size(), 1);
    if (got_q.size() > 0) check("ms_word", got_q[0], 8'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
